// File: rtl/cdc_hs_rx.sv
// Slow-domain receiver of a 4-phase req/ack handshake.
// Captures the word once the synchronized req is seen and offers it on valid/ready.
module cdc_hs_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  clk_slow,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ack_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  xfer_cnt_o
);

  typedef enum logic {
    IDLE,
    ACK
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_q, ack_d;
  logic                   valid_q, valid_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   req_s;
  logic                   slot_free;
  logic                   pop;
  logic                   capture;

  // req_i reaches the FSM only through this chain
  always_ff @(posedge clk_slow or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
    end
  end

  assign req_s     = sync_q[SYNC_STAGES-1];
  assign pop       = valid_q && ready_i;
  assign slot_free = !valid_q || ready_i;

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_s && slot_free) begin
          capture = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK;
        end else begin
          ack_d = 1'b0;
        end
      end
      ACK: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end else begin
          ack_d = 1'b1;
        end
      end
    endcase
  end

  // a capture wins over a pop, so pop+capture keeps valid high
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (capture) begin
      valid_d = 1'b1;
      data_d  = data_i;
      cnt_d   = cnt_q + 1'b1;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_slow or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ack_o      = ack_q;
  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign xfer_cnt_o = cnt_q;
  assign busy_o     = (state_q == ACK);

endmodule
